// File: rtl/seven_seg_pkg.sv
// Shared constants for the seven-segment display path.
package seven_seg_pkg;

    localparam int unsigned BCD_W = 4;
    localparam int unsigned SEG_W = 7;

    // Active-low segment patterns, bit order {g,f,e,d,c,b,a}
    localparam logic [SEG_W-1:0] SEG_BLANK = 7'b1111111;
    localparam logic [SEG_W-1:0] SEG_DIGIT [0:9] = '{
        7'b1000000,  // 0
        7'b1111001,  // 1
        7'b0100100,  // 2
        7'b0110000,  // 3
        7'b0011001,  // 4
        7'b0010010,  // 5
        7'b0000010,  // 6
        7'b1111000,  // 7
        7'b0000000,  // 8
        7'b0010000   // 9
    };

endpackage

// File: rtl/bcd_seg_decode.sv
// Combinational BCD nibble to active-low seven-segment pattern; non-decimal codes blank.
module bcd_seg_decode
    import seven_seg_pkg::*;
(
    input  logic [BCD_W-1:0] bcd_i,
    output logic [SEG_W-1:0] seg_c_o
);

    // Table lookup, anything above 9 is dark
    always_comb begin
        seg_c_o = SEG_BLANK;
        case (bcd_i)
            4'd0:    seg_c_o = SEG_DIGIT[0];
            4'd1:    seg_c_o = SEG_DIGIT[1];
            4'd2:    seg_c_o = SEG_DIGIT[2];
            4'd3:    seg_c_o = SEG_DIGIT[3];
            4'd4:    seg_c_o = SEG_DIGIT[4];
            4'd5:    seg_c_o = SEG_DIGIT[5];
            4'd6:    seg_c_o = SEG_DIGIT[6];
            4'd7:    seg_c_o = SEG_DIGIT[7];
            4'd8:    seg_c_o = SEG_DIGIT[8];
            4'd9:    seg_c_o = SEG_DIGIT[9];
            default: seg_c_o = SEG_BLANK;
        endcase
    end

endmodule

// File: rtl/bcd_seven_segment_mux.sv
// Time-multiplexed common-anode seven-segment driver with frame-synchronous
// double buffering, leading-zero blanking, per-digit decimal points and enable.
module bcd_seven_segment_mux
    import seven_seg_pkg::*;
#(
    parameter int unsigned NUM_DIGITS  = 4,
    parameter int unsigned REFRESH_DIV = 50000
) (
    input  logic                        clk,
    input  logic                        rst,
    input  logic                        en,
    input  logic                        load,
    input  logic [BCD_W*NUM_DIGITS-1:0] bcd_in,
    input  logic [NUM_DIGITS-1:0]       dp_in,
    input  logic                        lz_blank,
    output logic [SEG_W-1:0]            seg,
    output logic                        dp,
    output logic [NUM_DIGITS-1:0]       an,
    output logic                        frame_done
);

    localparam int unsigned CNT_W = (REFRESH_DIV > 1) ? $clog2(REFRESH_DIV) : 1;
    localparam int unsigned IDX_W = (NUM_DIGITS > 1) ? $clog2(NUM_DIGITS) : 1;
    localparam int unsigned BUS_W = BCD_W * NUM_DIGITS;

    logic [CNT_W-1:0]      cnt_q, cnt_d;
    logic [IDX_W-1:0]      idx_q, idx_d;
    logic [BUS_W-1:0]      pend_bcd_q, pend_bcd_d;
    logic [NUM_DIGITS-1:0] pend_dp_q, pend_dp_d;
    logic [BUS_W-1:0]      act_bcd_q, act_bcd_d;
    logic [NUM_DIGITS-1:0] act_dp_q, act_dp_d;
    logic [SEG_W-1:0]      seg_q, seg_d;
    logic                  dp_q, dp_d;
    logic [NUM_DIGITS-1:0] an_q, an_d;
    logic                  frame_done_q, frame_done_d;

    logic                  tick_c;
    logic                  wrap_c;
    logic [NUM_DIGITS-1:0] blank_c;
    logic                  zero_run_c;
    logic [BCD_W-1:0]      cur_nib_c;
    logic                  cur_dp_c;
    logic                  cur_blank_c;
    logic [SEG_W-1:0]      dec_seg_c;

    // Prescaler, scan index and frame-synchronous display buffers
    always_comb begin
        tick_c       = (cnt_q == CNT_W'(REFRESH_DIV - 1));
        wrap_c       = tick_c && (idx_q == IDX_W'(NUM_DIGITS - 1));
        cnt_d        = tick_c ? '0 : cnt_q + CNT_W'(1);
        idx_d        = idx_q;
        pend_bcd_d   = pend_bcd_q;
        pend_dp_d    = pend_dp_q;
        act_bcd_d    = act_bcd_q;
        act_dp_d     = act_dp_q;
        frame_done_d = wrap_c;

        if (tick_c) begin
            idx_d = wrap_c ? '0 : idx_q + IDX_W'(1);
        end
        if (load) begin
            pend_bcd_d = bcd_in;
            pend_dp_d  = dp_in;
        end
        // A load landing on the boundary bypasses pending so it shows immediately
        if (wrap_c) begin
            act_bcd_d = load ? bcd_in : pend_bcd_q;
            act_dp_d  = load ? dp_in  : pend_dp_q;
        end
    end

    // Leading-zero mask scanned from the most significant digit down; digit 0 always shows
    always_comb begin
        zero_run_c = 1'b1;
        blank_c    = '0;
        for (int k = NUM_DIGITS - 1; k >= 0; k--) begin
            zero_run_c = zero_run_c & (act_bcd_q[k*BCD_W +: BCD_W] == '0);
            blank_c[k] = lz_blank & zero_run_c & (k != 0);
        end
    end

    // Select the nibble, decimal point and blank flag for the digit being scanned
    always_comb begin
        cur_nib_c   = '0;
        cur_dp_c    = 1'b0;
        cur_blank_c = 1'b0;
        for (int k = 0; k < NUM_DIGITS; k++) begin
            if (idx_q == IDX_W'(k)) begin
                cur_nib_c   = act_bcd_q[k*BCD_W +: BCD_W];
                cur_dp_c    = act_dp_q[k];
                cur_blank_c = blank_c[k];
            end
        end
    end

    bcd_seg_decode u_decode (
        .bcd_i   (cur_nib_c),
        .seg_c_o (dec_seg_c)
    );

    // Pin drive values; disabled display forces every digit dark
    always_comb begin
        seg_d = SEG_BLANK;
        dp_d  = 1'b1;
        an_d  = '1;
        if (en) begin
            an_d  = ~(NUM_DIGITS'(1) << idx_q);
            seg_d = cur_blank_c ? SEG_BLANK : dec_seg_c;
            dp_d  = ~cur_dp_c;
        end
    end

    // State and output registers with synchronous reset
    always_ff @(posedge clk) begin
        if (rst) begin
            cnt_q        <= '0;
            idx_q        <= '0;
            pend_bcd_q   <= '0;
            pend_dp_q    <= '0;
            act_bcd_q    <= '0;
            act_dp_q     <= '0;
            seg_q        <= SEG_BLANK;
            dp_q         <= 1'b1;
            an_q         <= '1;
            frame_done_q <= 1'b0;
        end else begin
            cnt_q        <= cnt_d;
            idx_q        <= idx_d;
            pend_bcd_q   <= pend_bcd_d;
            pend_dp_q    <= pend_dp_d;
            act_bcd_q    <= act_bcd_d;
            act_dp_q     <= act_dp_d;
            seg_q        <= seg_d;
            dp_q         <= dp_d;
            an_q         <= an_d;
            frame_done_q <= frame_done_d;
        end
    end

    assign seg        = seg_q;
    assign dp         = dp_q;
    assign an         = an_q;
    assign frame_done = frame_done_q;

endmodule

// File: tb/tb_bcd_seven_segment_mux.sv
// Directed bench for bcd_seven_segment_mux with 4 digits and a 4-cycle digit slot.
module tb_bcd_seven_segment_mux;

    localparam logic [6:0] S0 = 7'b1000000;
    localparam logic [6:0] S1 = 7'b1111001;
    localparam logic [6:0] S2 = 7'b0100100;
    localparam logic [6:0] S3 = 7'b0110000;
    localparam logic [6:0] S4 = 7'b0011001;
    localparam logic [6:0] S5 = 7'b0010010;
    localparam logic [6:0] S6 = 7'b0000010;
    localparam logic [6:0] S7 = 7'b1111000;
    localparam logic [6:0] S8 = 7'b0000000;
    localparam logic [6:0] S9 = 7'b0010000;
    localparam logic [6:0] SB = 7'b1111111;

    logic        clk = 1'b0;
    logic        rst;
    logic        en;
    logic        load;
    logic [15:0] bcd_in;
    logic [3:0]  dp_in;
    logic        lz_blank;
    logic [6:0]  seg;
    logic        dp;
    logic [3:0]  an;
    logic        frame_done;

    int n_cmp = 0;
    int n_err = 0;

    always #5 clk = ~clk;

    bcd_seven_segment_mux #(
        .NUM_DIGITS  (4),
        .REFRESH_DIV (4)
    ) dut (
        .clk        (clk),
        .rst        (rst),
        .en         (en),
        .load       (load),
        .bcd_in     (bcd_in),
        .dp_in      (dp_in),
        .lz_blank   (lz_blank),
        .seg        (seg),
        .dp         (dp),
        .an         (an),
        .frame_done (frame_done)
    );

    task automatic check_val(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    task automatic step(input int n);
        repeat (n) @(negedge clk);
    endtask

    // Drive a one-cycle load strobe from the current negedge
    task automatic load_value(input logic [15:0] b, input logic [3:0] d);
        bcd_in = b;
        dp_in  = d;
        load   = 1'b1;
        @(negedge clk);
        load   = 1'b0;
    endtask

    // Advance to the next negedge where frame_done is high, bounded
    task automatic wait_frame(input string tag);
        int t;
        t = 0;
        @(negedge clk);
        while (frame_done !== 1'b1 && t < 40) begin
            @(negedge clk);
            t++;
        end
        check_val(tag, 32'(frame_done), 32'd1);
    endtask

    // Entered at a frame_done negedge; checks each digit slot of the following frame
    task automatic check_frame(input string tag, input logic [27:0] segs, input logic [3:0] dps);
        logic [3:0] an_exp;
        logic       dp_exp;
        for (int d = 0; d < 4; d++) begin
            step((d == 0) ? 2 : 4);
            an_exp = ~(4'b0001 << d);
            dp_exp = ~dps[d];
            check_val($sformatf("%s_an%0d", tag, d), 32'(an), 32'(an_exp));
            check_val($sformatf("%s_seg%0d", tag, d), 32'(seg), 32'(segs[d*7 +: 7]));
            check_val($sformatf("%s_dp%0d", tag, d), 32'(dp), 32'(dp_exp));
        end
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1, "watchdog");
    end

    initial begin
        logic [3:0] an_exp;
        int         fd_cnt;

        rst      = 1'b1;
        en       = 1'b1;
        load     = 1'b0;
        bcd_in   = '0;
        dp_in    = '0;
        lz_blank = 1'b0;

        // 1: reset values, then scan order and frame pulse rate
        step(3);
        check_val("rst_an", 32'(an), 32'hF);
        check_val("rst_seg", 32'(seg), 32'(SB));
        check_val("rst_dp", 32'(dp), 32'd1);
        check_val("rst_fd", 32'(frame_done), 32'd0);
        rst    = 1'b0;
        fd_cnt = 0;
        for (int i = 0; i < 32; i++) begin
            @(negedge clk);
            if ((i % 4) == 0 || i == 3) begin
                an_exp = ~(4'b0001 << ((i / 4) % 4));
                check_val($sformatf("scan_an_i%0d", i), 32'(an), 32'(an_exp));
            end
            if (i == 0) check_val("scan_seg0", 32'(seg), 32'(S0));
            if (i == 15) check_val("scan_fd15", 32'(frame_done), 32'd1);
            if (frame_done === 1'b1) fd_cnt++;
        end
        check_val("scan_fd_count", 32'(fd_cnt), 32'd2);

        // 2: mid-frame load held off until the boundary
        step(5);
        load_value(16'h1234, 4'b0010);
        check_val("t2_hold_seg", 32'(seg), 32'(S0));
        check_val("t2_hold_dp", 32'(dp), 32'd1);
        step(7);
        check_val("t2_hold_an3", 32'(an), 32'h7);
        check_val("t2_hold_seg3", 32'(seg), 32'(S0));
        wait_frame("t2_fd");
        check_frame("t2", {S1, S2, S3, S4}, 4'b0010);

        // 3: leading-zero blanking, dp still lit on a blanked digit
        lz_blank = 1'b1;
        load_value(16'h0050, 4'b0100);
        wait_frame("t3a_fd");
        check_frame("t3a", {SB, SB, S5, S0}, 4'b0100);
        load_value(16'h0000, 4'b0000);
        wait_frame("t3b_fd");
        check_frame("t3b", {SB, SB, SB, S0}, 4'b0000);

        // 4: non-decimal nibble blanks only its own slot
        lz_blank = 1'b0;
        load_value(16'h1A34, 4'b0000);
        wait_frame("t4_fd");
        check_frame("t4", {S1, SB, S3, S4}, 4'b0000);

        // 5: enable drop for 10 cycles, scan keeps its phase
        wait_frame("t5_fd");
        step(5);
        en = 1'b0;
        step(1);
        check_val("t5_off_an", 32'(an), 32'hF);
        check_val("t5_off_seg", 32'(seg), 32'(SB));
        check_val("t5_off_dp", 32'(dp), 32'd1);
        step(9);
        check_val("t5_off_an_late", 32'(an), 32'hF);
        en = 1'b1;
        step(1);
        check_val("t5_on_an", 32'(an), 32'h7);
        check_val("t5_on_seg", 32'(seg), 32'(S1));
        check_val("t5_on_fd", 32'(frame_done), 32'd1);
        step(1);
        check_val("t5_next_an", 32'(an), 32'hE);
        check_val("t5_next_seg", 32'(seg), 32'(S4));

        // 6: load coinciding with the boundary shows in the very next frame
        step(14);
        load_value(16'h9876, 4'b1000);
        check_val("t6_fd", 32'(frame_done), 32'd1);
        check_frame("t6", {S9, S8, S7, S6}, 4'b1000);

        // 7: reset mid-frame discards pending data
        wait_frame("t7_pre_fd");
        step(3);
        load_value(16'h5555, 4'b1111);
        step(2);
        rst = 1'b1;
        step(1);
        check_val("t7_rst_an", 32'(an), 32'hF);
        check_val("t7_rst_seg", 32'(seg), 32'(SB));
        check_val("t7_rst_dp", 32'(dp), 32'd1);
        check_val("t7_rst_fd", 32'(frame_done), 32'd0);
        rst = 1'b0;
        step(1);
        check_val("t7_rel_an", 32'(an), 32'hE);
        check_val("t7_rel_seg", 32'(seg), 32'(S0));
        wait_frame("t7_fd");
        check_frame("t7", {S0, S0, S0, S0}, 4'b0000);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
